piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//   Parallel-in/serial-out bit serializer: accepts WIDTH-bit words over a
//   valid/ready handshake and emits them one bit per clock on dout. Sits
//   directly upstream of the serial sequence-detector FSM; dout drives its
//   din input. Supports back-to-back words with no idle gap, plus a hold stall.
// PARAMETERS
//   WIDTH      8    bits per word (>=2)
//   MSB_FIRST  1    1: shift out bit WIDTH-1 first; 0: bit 0 first
//   IDLE_BIT   0    value driven on dout when no word is being sent
// PORTS
//   clk         in   1      rising-edge clock
//   rst         in   1      synchronous, active-high reset
//   load_valid  in   1      load_data is valid
//   load_ready  out  1      serializer can accept a word this cycle
//   load_data   in   WIDTH  parallel word to serialize
//   hold        in   1      1 = freeze shifting; dout/dout_valid hold value
//   dout        out  1      serial bit to downstream din
//   dout_valid  out  1      dout carries a word bit this cycle
//   done        out  1      1-cycle pulse; coincides with last bit of a word
//   busy        out  1      state != IDLE
// BEHAVIOUR
//   Reset (rst=1 at posedge): state=IDLE, shreg=0, bit_cnt=0,
//     dout=IDLE_BIT, dout_valid=0, done=0. load_ready=0 while rst=1.
//   States: IDLE, SHIFT.
//   Handshake: word accepted at posedge when load_valid && load_ready.
//     load_ready (comb) = !rst && (IDLE || (SHIFT && bit_cnt==WIDTH-1 && !hold)).
//   IDLE: on accept -> SHIFT, shreg<=load_data, bit_cnt<=0. Latency 1: the
//     first bit appears on dout with dout_valid=1 in the next cycle.
//   SHIFT: dout = current bit (registered output). Each cycle with hold=0,
//     bit_cnt++ and shreg shifts (left if MSB_FIRST, else right).
//   Last bit (bit_cnt==WIDTH-1): done=1 this cycle (0 if hold=1 and that
//     same bit is re-held; done pulses only once per word, on the cycle the
//     last bit is first presented). Next edge with hold=0:
//     - accept pending -> stay SHIFT, load new word, bit_cnt<=0; the first
//       bit of the new word follows immediately (no gap);
//     - no accept -> IDLE, dout=IDLE_BIT, dout_valid=0.
//   hold=1: shreg, bit_cnt, dout and dout_valid frozen; load_ready=0
//     (IDLE excepted: in IDLE hold has no effect and accepts proceed).
//   Back-to-back throughput: exactly WIDTH cycles per word, 100%.
//   rst mid-word: word aborted, no further bits; the next cycle shows
//     IDLE_BIT with dout_valid=0.
//   load_valid while not ready: ignored; upstream must hold the data.
//   busy = (state==SHIFT); stays 1 during hold.
// TESTING (WIDTH=8 unless noted)
//   1 MSB_FIRST=1, load 8'hB4 from IDLE -> dout 1,0,1,1,0,1,0,0 on cycles
//     1..8 after accept, dout_valid=1 for exactly 8 cycles, done on cycle 8.
//   2 Back-to-back 8'hFF then 8'h00 with load_valid held -> 16 consecutive
//     valid bits (8 ones, 8 zeros), no gap, done on cycles 8 and 16.
//   3 MSB_FIRST=0, load 8'h01 -> dout 1,0,0,0,0,0,0,0 (LSB first).
//   4 Send 8'hA5, hold=1 for 3 cycles after bit 3 -> bit 3 repeats 4 cycles,
//     sequence then resumes; total 11 valid cycles, one done pulse.
//   5 rst=1 after bit 4 of 8'hF0 -> next cycle dout=IDLE_BIT, dout_valid=0,
//     busy=0, done=0; a new word afterward serializes from bit 0.
//   6 WIDTH=7, load 7'b1010101 -> dout 1,0,1,0,1,0,1 then IDLE_BIT.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: accepts WIDTH-bit words over valid/ready
// and emits one bit per clock, back-to-back words with no gap, with a hold stall.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             hold,
  output logic             dout,
  output logic             dout_valid,
  output logic             done,
  output logic             busy
);

  localparam logic S_IDLE  = 1'b0;
  localparam logic S_SHIFT = 1'b1;

  localparam int             CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  logic             r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_bit_cnt;
  logic             r_stalled;

  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_shifted;

  assign w_last   = (r_bit_cnt == LAST);
  // NOTE: load_ready is combinational on rst/hold so a word is never accepted
  // on an edge where it would be discarded by reset or frozen by a stall.
  assign load_ready = !rst && ((r_state == S_IDLE) || (w_last && !hold));
  assign w_accept   = load_valid && load_ready;

  assign w_shifted = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                               : {1'b0, r_shreg[WIDTH-1:1]};

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_stalled <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_stalled <= 1'b0;
          if (w_accept) begin
            r_state   <= S_SHIFT;
            r_shreg   <= load_data;
            r_bit_cnt <= '0;
          end
        end
        default: begin
          if (hold) begin
            r_stalled <= 1'b1;
          end else begin
            r_stalled <= 1'b0;
            if (!w_last) begin
              r_shreg   <= w_shifted;
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end else if (w_accept) begin
              r_shreg   <= load_data;
              r_bit_cnt <= '0;
            end else begin
              r_state   <= S_IDLE;
              r_bit_cnt <= '0;
            end
          end
        end
      endcase
    end
  end

  // Outputs are a direct decode of registered state; r_stalled suppresses a
  // second done pulse while the last bit is re-presented under hold.
  assign dout_valid = (r_state == S_SHIFT);
  assign busy       = (r_state == S_SHIFT);
  assign dout       = (r_state == S_SHIFT) ? (MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0])
                                           : IDLE_BIT;
  assign done       = (r_state == S_SHIFT) && w_last && !r_stalled;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: three serializer variants checked every cycle against
// a queue-of-pending-bits reference model, plus directed stream checks.
module tb_piso_serializer;

  logic       clk;
  logic       rst;
  logic [2:0] lv;
  logic [2:0] hd;
  logic [7:0] ld [3];
  logic [2:0] rdy, dout, dv, dn, bz;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit mq [3][$];
  bit obs [3][$];
  bit mfresh [3];
  bit acc [3];
  int dcnt [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .rst(rst), .load_valid(lv[0]), .load_ready(rdy[0]), .load_data(ld[0]),
    .hold(hd[0]), .dout(dout[0]), .dout_valid(dv[0]), .done(dn[0]), .busy(bz[0]));

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .load_valid(lv[1]), .load_ready(rdy[1]), .load_data(ld[1]),
    .hold(hd[1]), .dout(dout[1]), .dout_valid(dv[1]), .done(dn[1]), .busy(bz[1]));

  piso_serializer #(.WIDTH(7), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_w7 (
    .clk(clk), .rst(rst), .load_valid(lv[2]), .load_ready(rdy[2]), .load_data(ld[2][6:0]),
    .hold(hd[2]), .dout(dout[2]), .dout_valid(dv[2]), .done(dn[2]), .busy(bz[2]));

  function automatic int wid(input int k);
    return (k == 2) ? 7 : 8;
  endfunction

  function automatic bit msb(input int k);
    return (k != 1);
  endfunction

  function automatic bit idlb(input int k);
    return (k == 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Expected bit order of a word, as the downstream detector would see it.
  task automatic push_word(input int k, input logic [7:0] w);
    for (int i = 0; i < wid(k); i++) begin
      mq[k].push_back(w[msb(k) ? (wid(k) - 1 - i) : i]);
    end
  endtask

  // One clock: compare all outputs to the model, then advance the model.
  task automatic tick();
    int  sz;
    bit  e_v, e_d, e_dn, e_r;
    #1;
    for (int k = 0; k < 3; k++) begin
      sz   = mq[k].size();
      e_v  = (sz > 0);
      e_d  = e_v ? mq[k][0] : idlb(k);
      e_dn = (sz == 1) && mfresh[k];
      e_r  = !rst && ((sz == 0) || ((sz == 1) && !hd[k]));
      check($sformatf("k%0d_cyc%0d_rdy_dout_vld_done_busy", k, cyc),
            {27'd0, rdy[k], dout[k], dv[k], dn[k], bz[k]},
            {27'd0, e_r, e_d, e_v, e_dn, e_v});
      if (dv[k] === 1'b1) obs[k].push_back(dout[k]);
      if (dn[k] === 1'b1) dcnt[k]++;
      acc[k] = lv[k] && e_r;
      if (rst) begin
        mq[k].delete();
        mfresh[k] = 1'b1;
      end else if (sz > 0 && hd[k]) begin
        mfresh[k] = 1'b0;
      end else begin
        if (sz > 0) void'(mq[k].pop_front());
        mfresh[k] = 1'b1;
        if (acc[k]) push_word(k, ld[k]);
      end
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic idle_all();
    lv = '0;
    hd = '0;
  endtask

  task automatic clear_obs();
    for (int k = 0; k < 3; k++) begin
      obs[k].delete();
      dcnt[k] = 0;
    end
  endtask

  function automatic logic [31:0] pack_obs(input int k);
    logic [31:0] v;
    v = '0;
    foreach (obs[k][i]) v = {v[30:0], obs[k][i]};
    return v;
  endfunction

  initial begin
    int n;
    idle_all();
    for (int k = 0; k < 3; k++) begin
      ld[k]     = '0;
      mfresh[k] = 1'b1;
      dcnt[k]   = 0;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    run(2);
    rst = 1'b0;
    run(2);

    // MSB-first 0xB4 from idle.
    clear_obs();
    lv[0] = 1'b1; ld[0] = 8'hB4;
    tick();
    lv[0] = 1'b0;
    run(10);
    check("t1_stream", pack_obs(0), 32'hB4);
    check("t1_valid_cycles", obs[0].size(), 8);
    check("t1_done_pulses", dcnt[0], 1);

    // Back-to-back 0xFF then 0x00 with valid held.
    clear_obs();
    lv[0] = 1'b1; ld[0] = 8'hFF;
    tick();
    ld[0] = 8'h00;
    n = 0;
    tick();
    while (!acc[0] && n < 20) begin
      tick();
      n++;
    end
    check("t2_second_accept", acc[0], 1);
    lv[0] = 1'b0;
    run(10);
    check("t2_stream", pack_obs(0), 32'hFF00);
    check("t2_valid_cycles", obs[0].size(), 16);
    check("t2_done_pulses", dcnt[0], 2);

    // LSB-first 0x01, idle level 1.
    clear_obs();
    lv[1] = 1'b1; ld[1] = 8'h01;
    tick();
    lv[1] = 1'b0;
    run(10);
    check("t3_stream", pack_obs(1), 32'h80);
    check("t3_valid_cycles", obs[1].size(), 8);

    // 0xA5 with hold for 3 cycles while bit 3 is shown.
    clear_obs();
    lv[0] = 1'b1; ld[0] = 8'hA5;
    tick();
    lv[0] = 1'b0;
    run(2);
    hd[0] = 1'b1;
    run(3);
    hd[0] = 1'b0;
    run(10);
    check("t4_stream", pack_obs(0), 32'h5E5);
    check("t4_valid_cycles", obs[0].size(), 11);
    check("t4_done_pulses", dcnt[0], 1);

    // Reset after bit 4 of 0xF0, then a fresh word.
    lv[0] = 1'b1; ld[0] = 8'hF0;
    tick();
    lv[0] = 1'b0;
    run(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_obs();
    tick();
    lv[0] = 1'b1; ld[0] = 8'h3C;
    tick();
    lv[0] = 1'b0;
    run(10);
    check("t5_stream_after_reset", pack_obs(0), 32'h3C);
    check("t5_valid_cycles", obs[0].size(), 8);

    // WIDTH=7 word 1010101.
    clear_obs();
    lv[2] = 1'b1; ld[2] = 8'h55;
    tick();
    lv[2] = 1'b0;
    run(9);
    check("t6_stream", pack_obs(2), 32'h55);
    check("t6_valid_cycles", obs[2].size(), 7);

    // Randomized traffic with holds and occasional reset.
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 3; k++) begin
        lv[k] = ($urandom_range(0, 3) != 0);
        hd[k] = ($urandom_range(0, 4) == 0);
        ld[k] = 8'($urandom);
      end
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    idle_all();
    run(30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
